// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the word index, buffers {instr, pc} in a 2-entry FIFO toward decode.
// Optional bounds check / HALT state enabled by defining IFU_BOUNDS_CHECK_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] PC_STEP   = 32'd1,
  parameter int unsigned MEM_DEPTH = 7
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] instruction_code,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned CNT_W    = 2;
  localparam logic [XLEN-1:0] LAST_IDX = XLEN'(MEM_DEPTH - 1);

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e           state_q;
  logic [XLEN-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  head_instr_q, head_pc_q, tail_instr_q, tail_pc_q;
  logic             out_valid_q;

  logic             pop_c, cap_c, push_c;
  logic [XLEN-1:0]  pc_next_c;
  logic [CNT_W-1:0] cnt_pop_c, cnt_d;
`ifdef IFU_BOUNDS_CHECK_EN
  logic             halted_q;
  logic             oob_c;
`endif

  // Handshake, capture eligibility and occupancy update
  always_comb begin
    pop_c     = out_valid_q & out_ready;
    cap_c     = (state_q == ST_RUN) && !redirect_valid && ((cnt_q != CNT_W'(2)) || pop_c);
`ifdef IFU_BOUNDS_CHECK_EN
    oob_c     = (pc_q >= XLEN'(MEM_DEPTH));
    push_c    = cap_c && !oob_c;
    pc_next_c = pc_q + PC_STEP;
`else
    push_c    = cap_c;
    pc_next_c = (pc_q == LAST_IDX) ? RESET_PC : pc_q + PC_STEP;
`endif
    cnt_pop_c = cnt_q - CNT_W'(pop_c);
    cnt_d     = cnt_pop_c + CNT_W'(push_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      cnt_q        <= '0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      tail_instr_q <= '0;
      tail_pc_q    <= '0;
      out_valid_q  <= 1'b0;
`ifdef IFU_BOUNDS_CHECK_EN
      halted_q     <= 1'b0;
`endif
    end else if (redirect_valid) begin
      // Flush: any same-cycle pop has already been accepted by decode
      state_q     <= ST_RUN;
      pc_q        <= redirect_pc;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef IFU_BOUNDS_CHECK_EN
      halted_q    <= 1'b0;
`endif
    end else begin
      if (pop_c) begin
        head_instr_q <= tail_instr_q;
        head_pc_q    <= tail_pc_q;
      end
      // Push lands in the first free slot after this cycle's pop
      if (push_c) begin
        pc_q <= pc_next_c;
        if (cnt_pop_c == '0) begin
          head_instr_q <= instruction_code;
          head_pc_q    <= pc_q;
        end else begin
          tail_instr_q <= instruction_code;
          tail_pc_q    <= pc_q;
        end
      end
      cnt_q       <= cnt_d;
      out_valid_q <= (cnt_d != '0);
`ifdef IFU_BOUNDS_CHECK_EN
      case (state_q)
        ST_RUN: begin
          if (cap_c && oob_c) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_RUN;
      endcase
`else
      state_q <= ST_RUN;
`endif
    end
  end

  assign PC        = pc_q;
  assign out_valid = out_valid_q;
  assign out_instr = head_instr_q;
  assign out_pc    = head_pc_q;
`ifdef IFU_BOUNDS_CHECK_EN
  assign halted    = halted_q;
`else
  assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory image model plus an expected-index scoreboard checked on each transfer.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PC;
  logic [31:0] instruction_code;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  logic [31:0] exp_q[$];

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .PC(PC), .instruction_code(instruction_code),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] img(input logic [31:0] idx);
    case (idx)
      32'd0:   return 32'h00940333;
      32'd1:   return 32'h413903b3;
      32'd2:   return 32'h017b4e33;
      32'd3:   return 32'h00f768b3;
      32'd4:   return 32'h00d67fb3;
      32'd5:   return 32'h019c1eb3;
      32'd6:   return 32'h01bd5f33;
      default: return 32'h00000013;
    endcase
  endfunction

  assign instruction_code = img(PC);

  // One clock; a transfer seen before the edge is scored against the queue head
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: out_pc=%0d out_instr=%h, no transfer expected", out_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        if (out_pc !== e || out_instr !== img(e)) begin
          errors++;
          $display("FAIL sb_word: out_pc=%0d out_instr=%h, want pc=%0d instr=%h", out_pc, out_instr, e, img(e));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b0;
    step(); step();
    vectors++; if (PC !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", PC); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vectors++; if (out_instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    vectors++; if (out_pc !== 32'd0) begin errors++; $display("FAIL reset_outpc: got %h want 0", out_pc); end
    vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_v0: got %b want 0", out_valid); end
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i));
    step();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== 32'h00940333) begin
      errors++; $display("FAIL stream_first: valid=%b pc=%0d instr=%h want 1/0/00940333", out_valid, out_pc, out_instr);
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    out_ready = 1'b0;
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_timeout: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      if (i >= 1) begin
        vectors++; if (out_valid !== 1'b1 || out_instr !== 32'h00940333 || out_pc !== 32'd0) begin
          errors++; $display("FAIL bp_hold: valid=%b instr=%h pc=%0d want 1/00940333/0", out_valid, out_instr, out_pc);
        end
      end
    end
    vectors++; if (PC !== 32'd2) begin errors++; $display("FAIL bp_pc: got %0d want 2", PC); end
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i));
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin step(); n++; end
    out_ready = 1'b0;
    vectors++; if (n != 3) begin errors++; $display("FAIL bp_gapless: took %0d cycles want 3", n); end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
    for (int i = 0; i < 10 && PC !== 32'd4; i++) step();
    vectors++; if (PC !== 32'd4) begin errors++; $display("FAIL redir_reach: PC=%0d want 4", PC); end
    redirect_valid = 1'b1; redirect_pc = 32'd1;
    step();
    redirect_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0 || PC !== 32'd1) begin
      errors++; $display("FAIL redir_flush: valid=%b PC=%0d want 0/1", out_valid, PC);
    end
    exp_q.push_back(32'd1); exp_q.push_back(32'd2);
    step();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'd1 || out_instr !== 32'h413903b3) begin
      errors++; $display("FAIL redir_target: valid=%b pc=%0d instr=%h want 1/1/413903b3", out_valid, out_pc, out_instr);
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    out_ready = 1'b0;
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL redir_timeout: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_pop_full();
    do_reset();
    step(); step(); step();
    vectors++; if (PC !== 32'd2) begin errors++; $display("FAIL rpf_full: PC=%0d want 2", PC); end
    exp_q.push_back(32'd0); exp_q.push_back(32'd5); exp_q.push_back(32'd6);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd5;
    step();
    redirect_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0 || PC !== 32'd5) begin
      errors++; $display("FAIL rpf_flush: valid=%b PC=%0d want 0/5", out_valid, PC);
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    out_ready = 1'b0;
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL rpf_timeout: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_bounds();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) exp_q.push_back(32'(i));
`ifndef IFU_BOUNDS_CHECK_EN
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
`endif
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    out_ready = 1'b0;
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL bounds_timeout: %0d left want 0", exp_q.size()); end
`ifdef IFU_BOUNDS_CHECK_EN
    step(); step();
    vectors++; if (halted !== 1'b1 || PC !== 32'd7 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bounds_halt: halted=%b PC=%0d valid=%b want 1/7/0", halted, PC, out_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    step();
    redirect_valid = 1'b0;
    vectors++; if (halted !== 1'b0 || PC !== 32'd0) begin
      errors++; $display("FAIL bounds_resume: halted=%b PC=%0d want 0/0", halted, PC);
    end
    exp_q.push_back(32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    out_ready = 1'b0;
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL bounds_restart: %0d left want 0", exp_q.size()); end
`else
    vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL bounds_nohalt: halted=%b want 0", halted); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(); step(); step();
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre: valid=%b want 1", out_valid); end
    reset = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b0 || PC !== 32'd0) begin
      errors++; $display("FAIL rmid_clear: valid=%b PC=%0d want 0/0", out_valid, PC);
    end
    reset = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    out_ready = 1'b0;
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_timeout: %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop_full();
    test_bounds();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
